ov7670_reset_sequencer: RTL and testbench



---
 rtl/ov7670_rstseq_pkg.sv | 28 ++
 rtl/rstseq_timer.sv | 41 ++++
 rtl/ov7670_reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_ov7670_reset_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_rstseq_pkg.sv
// +------------------------------------------------------------------+
// | ov7670_rstseq_pkg: shared types and register map for the OV7670  |
// | reset sequencer.                               Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

package ov7670_rstseq_pkg;

   typedef enum logic [1:0] {
      ST_OFF    = 2'd0,
      ST_PWRUP  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_READY  = 2'd3
   } state_t;

   localparam logic [1:0] ADDR_CONTROL  = 2'd0;
   localparam logic [1:0] ADDR_STATUS   = 2'd1;
   localparam logic [1:0] ADDR_T_RESET  = 2'd2;
   localparam logic [1:0] ADDR_T_SETTLE = 2'd3;

   localparam int CTRL_START_BIT = 0;
   localparam int CTRL_PDOWN_BIT = 1;
   localparam int STAT_READY_BIT = 2;
   localparam int STAT_IRQ_BIT   = 3;

endpackage

`default_nettype wire

// File: rtl/rstseq_timer.sv
// +------------------------------------------------------------------+
// | rstseq_timer: loadable down-counter that holds at zero.          |
// |                                                Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module rstseq_timer #(
   parameter int CNT_W = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_value,
   output logic             zero
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_value;
      end else if (count_q != '0) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/ov7670_reset_sequencer.sv
// +------------------------------------------------------------------+
// | ov7670_reset_sequencer: Avalon-MM timed PWDN/RESET# sequencer.   |
// | Optional interrupt: OV_RSTSEQ_IRQ_EN.          Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module ov7670_reset_sequencer
   import ov7670_rstseq_pkg::*;
#(
   parameter int CNT_W        = 20,
   parameter int DEF_T_RESET  = 50000,
   parameter int DEF_T_SETTLE = 50000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        cam_pwdn,
   output logic        cam_reset_n,
   output logic        sccb_en
`ifdef OV_RSTSEQ_IRQ_EN
   ,
   output logic        irq
`endif
);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] t_reset_q, t_reset_d;
   logic [CNT_W-1:0] t_settle_q, t_settle_d;
   logic             cam_pwdn_q, cam_pwdn_d;
   logic             cam_reset_n_q, cam_reset_n_d;
   logic             sccb_en_q, sccb_en_d;
   logic             wr_en, start_cmd, pdown_cmd;
   logic             timer_load, timer_zero;
   logic [CNT_W-1:0] timer_value;
   logic             irq_pend_bit;
   logic             unused_wd;

   assign wr_en     = chipselect & ~write_n;
   assign pdown_cmd = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_PDOWN_BIT];
   assign start_cmd = wr_en && (address == ADDR_CONTROL) && writedata[CTRL_START_BIT];
   assign unused_wd = &{1'b0, writedata};

   rstseq_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .zero       (timer_zero)
   );

   // Pins are decoded from the next state so they switch on the same edge as the FSM.
   always_comb begin
      state_d     = state_q;
      timer_load  = 1'b0;
      timer_value = t_reset_q;
      if (pdown_cmd) begin
         state_d = ST_OFF;
      end else if (start_cmd) begin
         state_d    = ST_PWRUP;
         timer_load = 1'b1;
      end else begin
         case (state_q)
            ST_PWRUP: if (timer_zero) begin
               state_d     = ST_SETTLE;
               timer_load  = 1'b1;
               timer_value = t_settle_q;
            end
            ST_SETTLE: if (timer_zero) state_d = ST_READY;
            default: ;
         endcase
      end
      cam_pwdn_d    = (state_d == ST_OFF);
      cam_reset_n_d = (state_d == ST_SETTLE) || (state_d == ST_READY);
      sccb_en_d     = (state_d == ST_READY);
   end

   always_comb begin
      t_reset_d  = t_reset_q;
      t_settle_d = t_settle_q;
      if (wr_en && (address == ADDR_T_RESET))  t_reset_d  = writedata[CNT_W-1:0];
      if (wr_en && (address == ADDR_T_SETTLE)) t_settle_d = writedata[CNT_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_OFF;
         t_reset_q     <= CNT_W'(DEF_T_RESET);
         t_settle_q    <= CNT_W'(DEF_T_SETTLE);
         cam_pwdn_q    <= 1'b1;
         cam_reset_n_q <= 1'b0;
         sccb_en_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         t_reset_q     <= t_reset_d;
         t_settle_q    <= t_settle_d;
         cam_pwdn_q    <= cam_pwdn_d;
         cam_reset_n_q <= cam_reset_n_d;
         sccb_en_q     <= sccb_en_d;
      end
   end

`ifdef OV_RSTSEQ_IRQ_EN
   logic irq_pend_q, irq_pend_d;

   // The set on READY entry is evaluated last so it wins over a same-cycle clear.
   always_comb begin
      irq_pend_d = irq_pend_q;
      if (pdown_cmd || (wr_en && (address == ADDR_STATUS) && writedata[STAT_IRQ_BIT])) begin
         irq_pend_d = 1'b0;
      end
      if ((state_d == ST_READY) && (state_q != ST_READY)) begin
         irq_pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_pend_q <= 1'b0;
      end else begin
         irq_pend_q <= irq_pend_d;
      end
   end

   assign irq          = irq_pend_q;
   assign irq_pend_bit = irq_pend_q;
`else
   assign irq_pend_bit = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_STATUS: begin
            readdata[1:0]          = state_q;
            readdata[STAT_READY_BIT] = (state_q == ST_READY);
            readdata[STAT_IRQ_BIT]   = irq_pend_bit;
         end
         ADDR_T_RESET:  readdata[CNT_W-1:0] = t_reset_q;
         ADDR_T_SETTLE: readdata[CNT_W-1:0] = t_settle_q;
         default: ;
      endcase
   end

   assign cam_pwdn    = cam_pwdn_q;
   assign cam_reset_n = cam_reset_n_q;
   assign sccb_en     = sccb_en_q;

endmodule

`default_nettype wire

// File: tb/tb_ov7670_reset_sequencer.sv
// +------------------------------------------------------------------+
// | tb_ov7670_reset_sequencer: scoreboard bench with a timeline      |
// | reference model.                               Revision: 1.0     |
// +------------------------------------------------------------------+
`default_nettype none

module tb_ov7670_reset_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic [31:0] writedata = 32'd0;
   logic [31:0] readdata;
   logic        cam_pwdn, cam_reset_n, sccb_en;
   logic        irq_sig;

   ov7670_reset_sequencer dut (
      .clk         (clk),
      .reset       (reset),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .cam_pwdn    (cam_pwdn),
      .cam_reset_n (cam_reset_n),
      .sccb_en     (sccb_en)
`ifdef OV_RSTSEQ_IRQ_EN
      ,
      .irq         (irq_sig)
`endif
   );

`ifndef OV_RSTSEQ_IRQ_EN
   assign irq_sig = 1'b0;
`endif

   always #5 clk = ~clk;

   typedef struct {
      int code;
      int tr;
      int ts;
      bit irq;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   // Reference model: a START opens a timeline; the phase is found from
   // the number of edges elapsed since that START.
   bit m_off = 1'b1;
   int m_since, m_tr_lat, m_ts_lat;
   int m_tr = 50000, m_ts = 50000;
   bit m_irq = 1'b0;

   function automatic int m_code();
      if (m_off) return 0;
      if (m_since <= m_tr_lat) return 1;
      if (m_since <= m_tr_lat + m_ts_lat + 1) return 2;
      return 3;
   endfunction

   initial forever begin
      @(posedge clk);
      if (reset) begin
         m_off = 1'b1; m_tr = 50000; m_ts = 50000; m_irq = 1'b0;
      end else begin
         bit wr;
         int prev;
         prev = m_code();
         wr   = chipselect && !write_n;
         if (wr && address == 2'd0 && writedata[1]) begin
            m_off = 1'b1;
            m_irq = 1'b0;
         end else if (wr && address == 2'd0 && writedata[0]) begin
            m_off = 1'b0; m_since = 0; m_tr_lat = m_tr;
         end else if (!m_off) begin
            if (m_since < 1000000) m_since++;
            if (m_since == m_tr_lat + 1) m_ts_lat = m_ts;
         end
         if (wr && address == 2'd2) m_tr = int'(writedata[19:0]);
         if (wr && address == 2'd3) m_ts = int'(writedata[19:0]);
`ifdef OV_RSTSEQ_IRQ_EN
         if (wr && address == 2'd1 && writedata[3]) m_irq = 1'b0;
         if (m_code() == 3 && prev != 3) m_irq = 1'b1;
`endif
      end
      exp_q.push_back('{code: m_code(), tr: m_tr, ts: m_ts, irq: m_irq});
   end

   // Monitor: one expected snapshot per edge, compared mid-cycle.
   initial forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
         n_cmp++; n_err++;
         $display("FAIL underflow: no expected entry at time %0t", $time);
      end else begin
         exp_t e;
         logic [34:0] act, req;
         logic [31:0] rd;
         e = exp_q.pop_front();
         case (address)
            2'd0: rd = 32'd0;
            2'd1: rd = {28'd0, e.irq, (e.code == 3), 2'(e.code)};
            2'd2: rd = 32'(e.tr);
            default: rd = 32'(e.ts);
         endcase
         req = {(e.code == 0), (e.code >= 2), (e.code == 3), rd};
         act = {cam_pwdn, cam_reset_n, sccb_en, readdata};
         n_cmp++;
         if (act !== req) begin
            n_err++;
            $display("FAIL pins/readdata addr=%0d t=%0t: got pwdn=%b rstn=%b sccb=%b rd=%h, want pwdn=%b rstn=%b sccb=%b rd=%h",
                     address, $time, act[34], act[33], act[32], act[31:0], req[34], req[33], req[32], req[31:0]);
         end
         n_cmp++;
         if (irq_sig !== e.irq) begin
            n_err++;
            $display("FAIL irq t=%0t: got %b want %b", $time, irq_sig, e.irq);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         reset      = 1'b0;
         chipselect = 1'($urandom_range(0, 1));
         write_n    = chipselect ? 1'b1 : 1'($urandom_range(0, 1));
         address    = 2'($urandom_range(0, 3));
         writedata  = $urandom;
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      reset = 1'b0; chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
   endtask

   task automatic do_reset(input int n);
      repeat (n) begin
         @(posedge clk); #1;
         reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
         address = 2'($urandom_range(0, 3));
      end
   endtask

   function automatic logic [31:0] small_t();
      return ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 12));
   endfunction

   initial begin
      do_reset(3);
      idle(3);
      // basic sequence T_RESET=3, T_SETTLE=2
      wr(2'd2, 32'd3); wr(2'd3, 32'd2); wr(2'd0, 32'd1);
      idle(10);
      wr(2'd0, 32'd3);
      idle(3);
      // zero-length phases
      wr(2'd2, 32'd0); wr(2'd3, 32'd0); wr(2'd0, 32'd1);
      idle(5);
      // timing write during a running phase
      wr(2'd2, 32'd10); wr(2'd0, 32'd1);
      idle(2);
      wr(2'd2, 32'd2);
      idle(12);
      wr(2'd0, 32'd1);
      idle(8);
      // reset during SETTLE
      wr(2'd2, 32'd3); wr(2'd3, 32'd5); wr(2'd0, 32'd1);
      idle(5);
      do_reset(1);
      idle(4);
      // interrupt set and clear
      wr(2'd2, 32'd1); wr(2'd3, 32'd1); wr(2'd0, 32'd1);
      idle(6);
      wr(2'd1, 32'd8);
      idle(3);
      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 19);
         case (r)
            0, 1, 2: wr(2'd0, ($urandom & 32'hFFFF_FFFC) | 32'd1);
            3:       wr(2'd0, $urandom | 32'd2);
            4:       wr(2'd0, $urandom);
            5, 6:    wr(2'd2, small_t());
            7, 8:    wr(2'd3, small_t());
            9:       wr(2'd1, $urandom);
            10: begin
               do_reset(1);
               wr(2'd2, small_t()); wr(2'd3, small_t());
            end
            default: idle($urandom_range(1, 6));
         endcase
      end
      idle(20);
      @(negedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
